// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a DEPTH x DATA_WIDTH word memory, with programmable wait states and error response.
// Define APB_SLV_PSTRB_EN to add the APB4 Pstrb port and byte-lane write masking.
module apb_slave_mem #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned MAX_WAIT   = 7
) (
   input  logic                    Pclk,
   input  logic                    Presetn,
   input  logic                    Psel,
   input  logic                    Penable,
   input  logic                    Pwrite,
   input  logic [ADDR_WIDTH-1:0]   Paddr,
   input  logic [DATA_WIDTH-1:0]   Pwdata,
`ifdef APB_SLV_PSTRB_EN
   input  logic [DATA_WIDTH/8-1:0] Pstrb,
`endif
   input  logic [2:0]              wait_cycles,
   output logic [DATA_WIDTH-1:0]   Prdata,
   output logic                    Pready,
   output logic                    Pslverr
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    write_q, write_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
   logic                    pready_q, pready_d;
   logic                    pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
   logic [STRB_W-1:0]       wr_strb_c;
   logic [CNT_W-1:0]        wait_sat_c;

`ifdef APB_SLV_PSTRB_EN
   logic [STRB_W-1:0]       strb_q, strb_d;
   assign wr_strb_c = strb_q;
`else
   assign wr_strb_c = {STRB_W{1'b1}};
`endif

   assign Prdata  = prdata_q;
   assign Pready  = pready_q;
   assign Pslverr = pslverr_q;

   function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return a >> OFF_W;
   endfunction

   // Misaligned byte offset or word index beyond the memory.
   function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] mask;
      mask = ADDR_WIDTH'(STRB_W - 1);
      return ((a & mask) != '0) || (32'(word_idx(a)) >= DEPTH);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
      return addr_bad(a) ? '0 : mem_q[IDX_W'(word_idx(a))];
   endfunction

   always_comb begin
      if (32'(wait_cycles) > MAX_WAIT) wait_sat_c = CNT_W'(MAX_WAIT);
      else                             wait_sat_c = CNT_W'(wait_cycles);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      prdata_d  = prdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      mem_d     = mem_q;
`ifdef APB_SLV_PSTRB_EN
      strb_d    = strb_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Penable without a preceding setup phase is ignored here.
            if (Psel && !Penable) begin
               addr_d  = Paddr;
               write_d = Pwrite;
               wdata_d = Pwdata;
               err_d   = addr_bad(Paddr);
`ifdef APB_SLV_PSTRB_EN
               strb_d  = Pstrb;
`endif
               if (wait_sat_c == '0) begin
                  pready_d  = 1'b1;
                  pslverr_d = addr_bad(Paddr);
                  if (!Pwrite) prdata_d = rd_word(Paddr);
                  state_d   = S_RESP;
               end else begin
                  cnt_d   = wait_sat_c - CNT_W'(1);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!Psel) begin
               state_d = S_IDLE;
            end else if (Penable) begin
               if (cnt_q == '0) begin
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  if (!write_q) prdata_d = rd_word(addr_q);
                  state_d   = S_RESP;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         S_RESP: begin
            if (!Psel) begin
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               state_d   = S_IDLE;
            end else if (Penable) begin
               if (write_q && !err_q) begin
                  for (int b = 0; b < STRB_W; b++) begin
                     if (wr_strb_c[b]) mem_d[IDX_W'(word_idx(addr_q))][b*8 +: 8] = wdata_q[b*8 +: 8];
                  end
               end
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Pclk or negedge Presetn) begin
      if (!Presetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         mem_q     <= mem_d;
      end
   end

`ifdef APB_SLV_PSTRB_EN
   always_ff @(posedge Pclk or negedge Presetn) begin
      if (!Presetn) strb_q <= '0;
      else          strb_q <= strb_d;
   end
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed plus randomized bench for apb_slave_mem against an array-based memory model.
module tb_apb_slave_mem;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned MAX_WAIT = 7;
   localparam int unsigned BYTES = DW / 8;
`ifdef APB_SLV_PSTRB_EN
   localparam bit HAS_STRB = 1'b1;
`else
   localparam bit HAS_STRB = 1'b0;
`endif

   logic          Pclk, Presetn, Psel, Penable, Pwrite;
   logic [AW-1:0] Paddr;
   logic [DW-1:0] Pwdata, Prdata;
   logic [2:0]    wait_cycles;
   logic          Pready, Pslverr;
`ifdef APB_SLV_PSTRB_EN
   logic [BYTES-1:0] Pstrb;
`endif

   apb_slave_mem dut (
      .Pclk(Pclk), .Presetn(Presetn), .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata),
`ifdef APB_SLV_PSTRB_EN
      .Pstrb(Pstrb),
`endif
      .wait_cycles(wait_cycles), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
   );

   initial Pclk = 1'b0;
   always #5 Pclk = ~Pclk;

   logic [DW-1:0] model [DEPTH];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_bad(input logic [AW-1:0] a);
      return (int'(a) % BYTES != 0) || (int'(a) / BYTES >= DEPTH);
   endfunction

   // One APB transfer; cycles = access cycles to Pready, -1 on abort, 0 on timeout.
   task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [BYTES-1:0] strb, input logic [2:0] wt, input int abort_after,
                       output logic [DW-1:0] rdata, output logic slverr, output int cycles);
      @(negedge Pclk);
      Psel = 1'b1; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = wd; wait_cycles = wt;
`ifdef APB_SLV_PSTRB_EN
      Pstrb = strb;
`else
      if (strb == '0) Pwdata = wd;
`endif
      cycles = 0; rdata = '0; slverr = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge Pclk);
         Penable = 1'b1;
         wait_cycles = 3'($urandom);
         if (abort_after > 0 && k > abort_after) begin
            check("no_ready_before_abort", 32'(Pready), 32'd0);
            Psel = 1'b0; Penable = 1'b0;
            cycles = -1;
            return;
         end
         if (Pready === 1'b1) begin
            cycles = k; rdata = Prdata; slverr = Pslverr;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL timeout: no Pready within 20 access cycles at addr %h", addr);
   endtask

   // Transfer checked against the model; model updated on successful writes.
   task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [BYTES-1:0] strb, input logic [2:0] wt, input string tag);
      logic [DW-1:0] rd; logic se; int cyc; int wsat; bit bad; int idx;
      bad  = ref_bad(addr);
      idx  = int'(addr) / BYTES;
      wsat = (int'(wt) > MAX_WAIT) ? MAX_WAIT : int'(wt);
      xfer(wr, addr, wd, strb, wt, 0, rd, se, cyc);
      if (cyc == 0) return;
      check({tag, "_latency"}, 32'(cyc), 32'(wsat + 1));
      check({tag, "_slverr"}, 32'(se), 32'(bad));
      if (!wr) check({tag, "_rdata"}, rd, bad ? 32'd0 : model[idx]);
      if (wr && !bad) begin
         for (int b = 0; b < BYTES; b++)
            if (!HAS_STRB || strb[b]) model[idx][b*8 +: 8] = wd[b*8 +: 8];
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Pclk);
         Psel = 1'b0; Penable = 1'b0;
         check("idle_ready", 32'(Pready), 32'd0);
      end
   endtask

   initial begin
      logic [DW-1:0] rd; logic se; int cyc;
      logic [AW-1:0] ra;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      Presetn = 1'b0; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
      Paddr = '0; Pwdata = '0; wait_cycles = '0;
`ifdef APB_SLV_PSTRB_EN
      Pstrb = '0;
`endif
      repeat (3) @(negedge Pclk);
      check("rst_pready", 32'(Pready), 32'd0);
      check("rst_pslverr", 32'(Pslverr), 32'd0);
      check("rst_prdata", Prdata, 32'd0);
      Presetn = 1'b1;

      run_xfer(1'b0, 8'h04, '0, '0, 3'd0, "t1_read");
      run_xfer(1'b1, 8'h08, 32'hDEADBEEF, '1, 3'd3, "t2_write");
      run_xfer(1'b0, 8'h08, '0, '0, 3'd0, "t2_read");
      check("t2_value", model[2], 32'hDEADBEEF);

      idle(1);
      run_xfer(1'b1, 8'h40, 32'hCAFEF00D, '1, 3'd1, "t3_wr_range");
      run_xfer(1'b1, 8'h06, 32'h12345678, '1, 3'd0, "t3_wr_misalign");
      run_xfer(1'b0, 8'h40, '0, '0, 3'd2, "t3_rd_range");
      run_xfer(1'b0, 8'h04, '0, '0, 3'd0, "t3_rd_word1");
      run_xfer(1'b0, 8'h08, '0, '0, 3'd0, "t3_rd_word2");

      run_xfer(1'b1, 8'h00, 32'h11, '1, 3'd0, "t4_b2b_wr");
      run_xfer(1'b0, 8'h00, '0, '0, 3'd0, "t4_b2b_rd");

      idle(1);
      xfer(1'b1, 8'h0C, 32'h55AA55AA, '1, 3'd5, 2, rd, se, cyc);
      check("t5_aborted", 32'(cyc), 32'hFFFF_FFFF);
      idle(2);
      run_xfer(1'b0, 8'h0C, '0, '0, 3'd0, "t5_rd");

      // Penable without setup must not start a transfer.
      @(negedge Pclk); Psel = 1'b1; Penable = 1'b1; Pwrite = 1'b0; Paddr = 8'h08;
      @(negedge Pclk); check("viol_ready1", 32'(Pready), 32'd0);
      @(negedge Pclk); check("viol_ready2", 32'(Pready), 32'd0);
      idle(1);

`ifdef APB_SLV_PSTRB_EN
      run_xfer(1'b1, 8'h10, 32'hAABBCCDD, 4'b1111, 3'd0, "t6_full");
      run_xfer(1'b1, 8'h10, 32'h11223344, 4'b0101, 3'd1, "t6_strb");
      run_xfer(1'b0, 8'h10, '0, '0, 3'd0, "t6_rd");
      check("t6_value", model[4], 32'hAA22CC44);
      run_xfer(1'b1, 8'h10, 32'hFFFFFFFF, 4'b0000, 3'd0, "t6_nostrb");
      run_xfer(1'b0, 8'h10, '0, '0, 3'd2, "t6_rd2");
`endif

      for (int n = 0; n < 80; n++) begin
         ra = AW'($urandom_range(0, 8'h4F));
         if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
         run_xfer(1'($urandom), ra, $urandom, BYTES'($urandom), 3'($urandom), "rand");
         if ($urandom_range(0, 3) == 0) idle(1);
      end

      // Reset during a pending write discards it and clears everything.
      run_xfer(1'b1, 8'h14, 32'h0BADCAFE, '1, 3'd0, "rst_pre_wr");
      run_xfer(1'b0, 8'h14, '0, '0, 3'd0, "rst_pre_rd");
      @(negedge Pclk); Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 8'h18; Pwdata = 32'h77777777;
      wait_cycles = 3'd6;
      @(negedge Pclk); Penable = 1'b1;
      @(negedge Pclk);
      #1 Presetn = 1'b0;
      #1;
      check("midrst_pready", 32'(Pready), 32'd0);
      check("midrst_prdata", Prdata, 32'd0);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      Psel = 1'b0; Penable = 1'b0;
      @(negedge Pclk); Presetn = 1'b1;
      run_xfer(1'b0, 8'h14, '0, '0, 3'd0, "midrst_rd14");
      run_xfer(1'b0, 8'h18, '0, '0, 3'd1, "midrst_rd18");
      idle(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "global timeout");
   end
endmodule
